// File: rtl/ram_burst_ctrl_if.sv
// Bus bundle for ram_burst_ctrl: command, write stream, read stream and RAM pins.
interface ram_burst_ctrl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
);

    // Command
    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;

    // Write stream (producer -> RAM)
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    // Read stream (RAM -> consumer)
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    // RAM pins
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Controller view
    modport slave (
        input  start, rw, start_addr, len,
        input  s_valid, s_data,
        input  m_ready,
        input  ram_rdata,
        output busy, done,
        output s_ready,
        output m_valid, m_data,
        output ram_addr, ram_we, ram_wdata
    );

    // Environment view (command source, stream endpoints, RAM)
    modport master (
        output start, rw, start_addr, len,
        output s_valid, s_data,
        output m_ready,
        output ram_rdata,
        input  busy, done,
        input  s_ready,
        input  m_valid, m_data,
        input  ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for a single-port RAM: turns a start command into a run of
// consecutive, wrapping accesses fed from / drained to valid-ready streams.
module ram_burst_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_burst_ctrl_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  rem;
    logic              busy_q;
    logic              done_q;
    logic              s_ready_q;
    logic              m_valid_q;
    logic [DATA_W-1:0] m_data_q;

    logic [LEN_W-1:0]  len_eff_c;
    logic              w_beat_c;
    logic              m_take_c;
    logic              m_load_c;

    // Requested length clamped to the RAM depth
    assign len_eff_c = (bus.len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.len;

    // A write beat lands on every WRITE cycle the producer offers data
    assign w_beat_c = (state == ST_WRITE) && bus.s_valid;

    // Consumer accepts the beat currently held in the output register
    assign m_take_c = m_valid_q && bus.m_ready;

    // Output register may refill when empty or draining, while beats remain
    assign m_load_c = (state == ST_READ) && (!m_valid_q || bus.m_ready) && (rem != '0);

    // Burst sequencing, address/beat counters and registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            rem       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (len_eff_c == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            ptr    <= bus.start_addr;
                            rem    <= len_eff_c;
                            busy_q <= 1'b1;
                            if (bus.rw) begin
                                state     <= ST_WRITE;
                                s_ready_q <= 1'b1;
                            end else begin
                                state <= ST_READ;
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    if (bus.s_valid) begin
                        ptr <= ptr + ADDR_W'(1);
                        rem <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) begin
                            state     <= ST_IDLE;
                            busy_q    <= 1'b0;
                            s_ready_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end

                ST_READ: begin
                    if (m_load_c) begin
                        m_data_q  <= bus.ram_rdata;
                        m_valid_q <= 1'b1;
                        ptr       <= ptr + ADDR_W'(1);
                        rem       <= rem - LEN_W'(1);
                    end else if (m_take_c) begin
                        m_valid_q <= 1'b0;
                    end
                    if ((rem == '0) && m_take_c) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    busy_q    <= 1'b0;
                    s_ready_q <= 1'b0;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Drive the bus from the registered state; write strobe follows s_valid
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.s_ready   = s_ready_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.ram_addr  = ptr;
    assign bus.ram_we    = w_beat_c;
    assign bus.ram_wdata = bus.s_data;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural 64x8 RAM attached.
module tb_ram_burst_ctrl;

    logic clk;
    logic rst_n;

    int checks;
    int errors;
    int we_total;
    int done_total;

    logic [7:0] mem [64];

    ram_burst_ctrl_if #(.DATA_W(8), .ADDR_W(6)) bus();

    ram_burst_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read, write on rising edge
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    end
    assign bus.ram_rdata = mem[bus.ram_addr];

    // Event counters for write strobes and done pulses
    always @(posedge clk) begin
        if (bus.ram_we) we_total <= we_total + 1;
        if (bus.done) done_total <= done_total + 1;
    end

    initial begin
        we_total   = 0;
        done_total = 0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.rw         = 1'b0;
        bus.start_addr = '0;
        bus.len        = '0;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.m_ready    = 1'b0;
        repeat (3) step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", bus.m_valid); end
        checks++; if (bus.m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h exp 00", bus.m_data); end
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b exp 0", bus.s_ready); end
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b exp 0", bus.ram_we); end
        checks++; if (bus.ram_addr !== 6'd0) begin errors++; $display("FAIL reset_ram_addr got %0d exp 0", bus.ram_addr); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_wrap();
        int k;
        int c;
        int we0;
        int dn0;
        we0 = we_total;
        dn0 = done_total;
        bus.start_addr = 6'd60;
        bus.len        = 7'd8;
        bus.rw         = 1'b1;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.s_ready !== 1'b1) begin errors++; $display("FAIL wr_start busy=%b s_ready=%b exp 1 1", bus.busy, bus.s_ready); end
        k = 0;
        c = 0;
        while (k < 8 && c < 40) begin
            bus.s_valid = (c % 3 != 2);
            bus.s_data  = 8'(8'h10 + k);
            #1;
            checks++; if (bus.ram_we !== bus.s_valid) begin errors++; $display("FAIL wr_we c=%0d got %b exp %b", c, bus.ram_we, bus.s_valid); end
            checks++; if (bus.ram_addr !== 6'(60 + k)) begin errors++; $display("FAIL wr_addr k=%0d got %0d exp %0d", k, bus.ram_addr, 6'(60 + k)); end
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL wr_early_done c=%0d got %b exp 0", c, bus.done); end
            @(posedge clk);
            #1;
            if (bus.s_valid) k++;
            c++;
        end
        bus.s_valid = 1'b0;
        checks++; if (k !== 8) begin errors++; $display("FAIL wr_timeout beats got %0d exp 8", k); end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL wr_done got %b exp 1", bus.done); end
        checks++; if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0) begin errors++; $display("FAIL wr_end busy=%b s_ready=%b exp 0 0", bus.busy, bus.s_ready); end
        step();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL wr_done_width got %b exp 0", bus.done); end
        checks++; if (we_total - we0 !== 8) begin errors++; $display("FAIL wr_we_count got %0d exp 8", we_total - we0); end
        checks++; if (done_total - dn0 !== 1) begin errors++; $display("FAIL wr_done_count got %0d exp 1", done_total - dn0); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (mem[6'(60 + i)] !== 8'(8'h10 + i)) begin errors++; $display("FAIL wr_mem addr=%0d got %h exp %h", 6'(60 + i), mem[6'(60 + i)], 8'(8'h10 + i)); end
        end
    endtask

    task automatic test_read();
        bus.start_addr = 6'd60;
        bus.len        = 7'd8;
        bus.rw         = 1'b0;
        bus.start      = 1'b1;
        step();
        bus.start   = 1'b0;
        bus.m_ready = 1'b1;
        checks++; if (bus.m_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL rd_e0 m_valid=%b busy=%b exp 0 1", bus.m_valid, bus.busy); end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL rd_valid beat=%0d got %b exp 1", i, bus.m_valid); end
            checks++; if (bus.m_data !== 8'(8'h10 + i)) begin errors++; $display("FAIL rd_data beat=%0d got %h exp %h", i, bus.m_data, 8'(8'h10 + i)); end
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rd_early_done beat=%0d got %b exp 0", i, bus.done); end
        end
        step();
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL rd_end done=%b busy=%b exp 1 0", bus.done, bus.busy); end
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rd_end_valid got %b exp 0", bus.m_valid); end
        bus.m_ready = 1'b0;
        step();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rd_done_width got %b exp 0", bus.done); end
    endtask

    task automatic test_read_stall();
        int n;
        int c;
        logic stall_prev;
        logic [7:0] prev;
        logic seen_done;
        bus.start_addr = 6'd60;
        bus.len        = 7'd8;
        bus.rw         = 1'b0;
        bus.start      = 1'b1;
        step();
        bus.start  = 1'b0;
        n          = 0;
        stall_prev = 1'b0;
        prev       = '0;
        seen_done  = 1'b0;
        for (c = 0; c < 60; c++) begin
            if (bus.done) begin
                seen_done = 1'b1;
                break;
            end
            if (stall_prev) begin
                checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== prev) begin errors++; $display("FAIL rs_hold c=%0d valid=%b data=%h exp 1 %h", c, bus.m_valid, bus.m_data, prev); end
            end
            bus.m_ready = (c % 3 == 0);
            if (bus.m_valid && bus.m_ready) begin
                checks++; if (bus.m_data !== 8'(8'h10 + n)) begin errors++; $display("FAIL rs_data beat=%0d got %h exp %h", n, bus.m_data, 8'(8'h10 + n)); end
                n++;
            end
            stall_prev = bus.m_valid && !bus.m_ready;
            prev       = bus.m_data;
            step();
        end
        bus.m_ready = 1'b0;
        checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL rs_timeout done got %b exp 1", seen_done); end
        checks++; if (n !== 8) begin errors++; $display("FAIL rs_beats got %0d exp 8", n); end
        checks++; if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL rs_end busy=%b m_valid=%b exp 0 0", bus.busy, bus.m_valid); end
        step();
    endtask

    task automatic test_zero_len_and_ignore();
        int we0;
        int dn0;
        we0 = we_total;
        bus.start_addr = 6'd10;
        bus.len        = 7'd0;
        bus.rw         = 1'b1;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL z_done got %b exp 1", bus.done); end
        checks++; if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0) begin errors++; $display("FAIL z_idle busy=%b s_ready=%b exp 0 0", bus.busy, bus.s_ready); end
        step();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL z_done_width got %b exp 0", bus.done); end
        checks++; if (we_total - we0 !== 0) begin errors++; $display("FAIL z_no_write got %0d exp 0", we_total - we0); end

        dn0 = done_total;
        bus.start_addr = 6'd20;
        bus.len        = 7'd3;
        bus.rw         = 1'b1;
        bus.start      = 1'b1;
        step();
        bus.start_addr = 6'd40;
        bus.len        = 7'd2;
        bus.rw         = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(8'hA0 + k);
            if (k == 2) bus.start = 1'b0;
            #1;
            checks++; if (bus.ram_addr !== 6'(20 + k)) begin errors++; $display("FAIL ign_addr k=%0d got %0d exp %0d", k, bus.ram_addr, 20 + k); end
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL ign_end done=%b busy=%b exp 1 0", bus.done, bus.busy); end
        step();
        checks++; if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL ign_not_queued busy=%b m_valid=%b exp 0 0", bus.busy, bus.m_valid); end
        checks++; if (done_total - dn0 !== 1) begin errors++; $display("FAIL ign_done_count got %0d exp 1", done_total - dn0); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem[20 + i] !== 8'(8'hA0 + i)) begin errors++; $display("FAIL ign_mem addr=%0d got %h exp %h", 20 + i, mem[20 + i], 8'(8'hA0 + i)); end
        end
    endtask

    task automatic test_full_depth();
        int k;
        int we0;
        we0 = we_total;
        bus.start_addr = 6'd5;
        bus.len        = 7'd100;
        bus.rw         = 1'b1;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        k = 0;
        while (k < 64 && !bus.done) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(8'h80 + k);
            #1;
            checks++; if (bus.ram_addr !== 6'(5 + k)) begin errors++; $display("FAIL fd_addr k=%0d got %0d exp %0d", k, bus.ram_addr, 6'(5 + k)); end
            @(posedge clk);
            #1;
            k++;
        end
        bus.s_valid = 1'b0;
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL fd_end done=%b busy=%b exp 1 0", bus.done, bus.busy); end
        checks++; if (we_total - we0 !== 64) begin errors++; $display("FAIL fd_we_count got %0d exp 64", we_total - we0); end
        checks++; if (bus.ram_addr !== 6'd5) begin errors++; $display("FAIL fd_ptr got %0d exp 5", bus.ram_addr); end
        for (int a = 0; a < 64; a++) begin
            checks++; if (mem[a] !== 8'(8'h80 + ((a - 5 + 64) % 64))) begin errors++; $display("FAIL fd_mem addr=%0d got %h exp %h", a, mem[a], 8'(8'h80 + ((a - 5 + 64) % 64))); end
        end
        step();
    endtask

    task automatic test_reset_mid_burst();
        int we0;
        int dn0;
        we0 = we_total;
        dn0 = done_total;
        bus.start_addr = 6'd30;
        bus.len        = 7'd8;
        bus.rw         = 1'b1;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(8'h55 + k);
            step();
        end
        bus.s_data = 8'h58;
        #1;
        checks++; if (bus.ram_we !== 1'b1) begin errors++; $display("FAIL rm_pre_we got %b exp 1", bus.ram_we); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL rm_we got %b exp 0", bus.ram_we); end
        checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rm_s_ready got %b exp 0", bus.s_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", bus.busy); end
        step();
        rst_n       = 1'b1;
        bus.s_valid = 1'b0;
        step();
        checks++; if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0) begin errors++; $display("FAIL rm_idle busy=%b s_ready=%b exp 0 0", bus.busy, bus.s_ready); end
        checks++; if (bus.ram_addr !== 6'd0) begin errors++; $display("FAIL rm_addr got %0d exp 0", bus.ram_addr); end
        checks++; if (done_total - dn0 !== 0) begin errors++; $display("FAIL rm_no_done got %0d exp 0", done_total - dn0); end
        checks++; if (we_total - we0 !== 3) begin errors++; $display("FAIL rm_we_count got %0d exp 3", we_total - we0); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_v;
            exp_v = (i < 3) ? 8'(8'h55 + i) : 8'(8'h80 + 30 + i - 5);
            checks++; if (mem[30 + i] !== exp_v) begin errors++; $display("FAIL rm_mem addr=%0d got %h exp %h", 30 + i, mem[30 + i], exp_v); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_wrap();
        test_read();
        test_read_stall();
        test_zero_len_and_ignore();
        test_full_depth();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
